mem_axi_master: RTL

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

---
 rtl/mem_axi_master_if.sv | 77 +++++++
 rtl/mem_axi_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_master_if.sv
// mem_axi_master_if: AXI4 bus bundle between mem_axi_master and a memory
// slave. The AR, R, AW, W and B channels are included; ID, size and burst
// fields are left out because the master uses one ID and full-width INCR
// bursts.
//
// Parameters: ADDR_W (address width), DATA_W (32 or 64), LEN_W (AxLEN width).
// Modports:
//   master - drives ARVALID/ARADDR/ARLEN/ARPROT, RREADY,
//            AWVALID/AWADDR/AWPROT, WVALID/WDATA/WSTRB/WLAST, BREADY;
//            samples ARREADY, RVALID/RDATA/RRESP/RLAST, AWREADY,
//            WREADY, BVALID/BRESP.
//   slave  - the mirror image of master.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where VALID and READY are both high. VALID, once raised, holds its payload
// stable until that edge. READY may come before, with or after VALID.
interface mem_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
);
  localparam int STRB_W = DATA_W / 8;

  // read address
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARPROT;
  // read data
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  // write address
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  // write data
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  // write response
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;

  modport master (
    output ARVALID, ARADDR, ARLEN, ARPROT,
    input  ARREADY,
    input  RVALID, RDATA, RRESP, RLAST,
    output RREADY,
    output AWVALID, AWADDR, AWPROT,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST,
    input  WREADY,
    input  BVALID, BRESP,
    output BREADY
  );

  modport slave (
    input  ARVALID, ARADDR, ARLEN, ARPROT,
    output ARREADY,
    output RVALID, RDATA, RRESP, RLAST,
    input  RREADY,
    input  AWVALID, AWADDR, AWPROT,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST,
    output WREADY,
    output BVALID, BRESP,
    input  BREADY
  );
endinterface

// File: rtl/mem_axi_master.sv
// mem_axi_master: turns single requests from a simple req/resp port into AXI
// transactions. A read becomes one INCR burst of req_len+1 beats. A write
// becomes one single-beat AW+W pair. Only one transaction is in flight.
//
// Ports:
//   ACLK, ARESET   clock, synchronous active-high reset
//   req_valid/req_ready, req_we, req_addr, req_len, req_wdata, req_wstrb
//                  request side: a transfer happens on a clock edge where
//                  both req_valid and req_ready are high. The requester
//                  holds req_valid and the payload until then.
//   resp_valid, resp_rdata, resp_last, resp_err
//                  response side: resp_valid is a one-cycle pulse per
//                  response beat. There is no back-pressure.
//   axi            AXI bus (mem_axi_master_if.master)
//   dbg_state      current FSM state (IDLE=0, RADDR=1, RDATA=2, WREQ=3,
//                  WRESP=4)
//
// Build option: define MEM_AXI_ALIGN_CHECK_EN to reject requests whose address
// is not aligned to the bus width. Such a request gets an immediate error
// response and causes no AXI traffic. By default, misaligned addresses go to
// the bus unchanged.
//
// Every output is a flop, so no AXI input has a combinational path to an
// AXI output.
module mem_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_last,
  output logic                  resp_err,
  mem_axi_master_if.master      axi,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] beat_cnt;

  logic r_fire;
  logic last_beat;
  logic aw_done;
  logic w_done;
  logic misaligned;

  assign r_fire    = axi.RVALID && axi.RREADY;
  // ARLEN keeps the captured burst length for the whole read.
  assign last_beat = (beat_cnt == axi.ARLEN);
  // A channel counts as done once its VALID has dropped, or if it hands off
  // on this edge.
  assign aw_done   = !axi.AWVALID || axi.AWREADY;
  assign w_done    = !axi.WVALID  || axi.WREADY;

`ifdef MEM_AXI_ALIGN_CHECK_EN
  localparam int ALIGN_BITS = $clog2(DATA_W / 8);
  assign misaligned = (req_addr[ALIGN_BITS-1:0] != '0);
`else
  assign misaligned = 1'b0;
`endif

  assign axi.ARPROT = 3'b111;
  assign axi.AWPROT = 3'b111;
  assign dbg_state  = state;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_last   <= 1'b0;
      resp_err    <= 1'b0;
      axi.ARVALID <= 1'b0;
      axi.ARADDR  <= '0;
      axi.ARLEN   <= '0;
      axi.RREADY  <= 1'b0;
      axi.AWVALID <= 1'b0;
      axi.AWADDR  <= '0;
      axi.WVALID  <= 1'b0;
      axi.WDATA   <= '0;
      axi.WSTRB   <= '0;
      axi.WLAST   <= 1'b0;
      axi.BREADY  <= 1'b0;
    end else begin
      // Response fields are pulses. They are zero unless a beat lands
      // this cycle.
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            // Drop ready for at least one cycle so the same request is
            // never taken twice.
            req_ready <= 1'b0;
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_last  <= 1'b1;
            end else if (req_we) begin
              state       <= WREQ;
              axi.AWVALID <= 1'b1;
              axi.AWADDR  <= req_addr;
              axi.WVALID  <= 1'b1;
              axi.WDATA   <= req_wdata;
              axi.WSTRB   <= req_wstrb;
              axi.WLAST   <= 1'b1;
            end else begin
              state       <= RADDR;
              axi.ARVALID <= 1'b1;
              axi.ARADDR  <= req_addr;
              axi.ARLEN   <= req_len;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        RADDR: begin
          if (axi.ARREADY) begin
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b1;
            beat_cnt    <= '0;
            state       <= RDATA;
          end
        end

        RDATA: begin
          if (r_fire) begin
            resp_valid <= 1'b1;
            resp_rdata <= axi.RDATA;
            resp_last  <= axi.RLAST;
            // Our own beat count decides where the burst ends. If RLAST
            // disagrees with that count, the beat is flagged as an error.
            resp_err   <= (axi.RRESP != 2'b00) || (axi.RLAST != last_beat);
            if (last_beat) begin
              axi.RREADY <= 1'b0;
              beat_cnt   <= '0;
              req_ready  <= 1'b1;
              state      <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        WREQ: begin
          if (axi.AWREADY) begin
            axi.AWVALID <= 1'b0;
          end
          if (axi.WREADY) begin
            axi.WVALID <= 1'b0;
            axi.WLAST  <= 1'b0;
          end
          if (aw_done && w_done) begin
            axi.BREADY <= 1'b1;
            state      <= WRESP;
          end
        end

        WRESP: begin
          if (axi.BVALID) begin
            axi.BREADY <= 1'b0;
            resp_valid <= 1'b1;
            resp_last  <= 1'b1;
            resp_err   <= (axi.BRESP != 2'b00);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
